// File: rtl/pixel_pkg.sv
// Pixel and 3x3 window types shared by the image pipeline stages.
package pixel_pkg;

    localparam int unsigned CH_W   = 8;
    localparam int unsigned NUM_CH = 3;
    localparam int unsigned WIN    = 3;

    typedef struct packed {
        logic [CH_W-1:0] red;
        logic [CH_W-1:0] grn;
        logic [CH_W-1:0] blu;
    } pixel_t;

    typedef pixel_t [WIN-1:0][WIN-1:0] chunk_t;

    // Channel select by index: 0 = red, 1 = grn, 2 = blu.
    function automatic logic [CH_W-1:0] get_ch(pixel_t p, int unsigned c);
        case (c)
            0:       return p.red;
            1:       return p.grn;
            default: return p.blu;
        endcase
    endfunction

endpackage

// File: rtl/axis_if.sv
// Valid/ready stream interface carrying one DATA_TYPE payload per beat.
interface axis_if #(
    parameter type DATA_TYPE = logic
) ();

    logic     vld;
    logic     rdy;
    DATA_TYPE data;

    modport sink   (input vld, input data, output rdy);
    modport source (output vld, output data, input rdy);

endinterface

// File: rtl/median_filter_sort3.sv
// Combinational three-input sorter for one 8-bit channel.
module median_filter_sort3
    import pixel_pkg::*;
(
    input  logic [CH_W-1:0] a_i,
    input  logic [CH_W-1:0] b_i,
    input  logic [CH_W-1:0] c_i,
    output logic [CH_W-1:0] min_o,
    output logic [CH_W-1:0] med_o,
    output logic [CH_W-1:0] max_o
);

    logic [CH_W-1:0] lo_ab;
    logic [CH_W-1:0] hi_ab;
    logic [CH_W-1:0] lo_hc;

    // Order a/b, split the larger against c, then place the smaller of a/b.
    always_comb begin
        lo_ab = (a_i < b_i) ? a_i : b_i;
        hi_ab = (a_i < b_i) ? b_i : a_i;
        max_o = (hi_ab > c_i) ? hi_ab : c_i;
        lo_hc = (hi_ab > c_i) ? c_i : hi_ab;
        med_o = (lo_ab > lo_hc) ? lo_ab : lo_hc;
        min_o = (lo_ab > lo_hc) ? lo_hc : lo_ab;
    end

endmodule

// File: rtl/median_filter.sv
// Three-stage streaming 3x3 per-channel median filter with a global stall enable.
module median_filter
    import pixel_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    axis_if.sink   axis_i,
    axis_if.source axis_o
);

    logic   en_c;
    chunk_t in_c;
    logic   vld1_q;
    logic   vld2_q;
    logic   vld3_q;
    chunk_t win1_q;
    chunk_t win2_q;
    chunk_t out_q;
    chunk_t out_d;

    // Indexed [channel][row][0=min,1=med,2=max].
    logic [NUM_CH-1:0][WIN-1:0][2:0][CH_W-1:0] srt_d;
    logic [NUM_CH-1:0][WIN-1:0][2:0][CH_W-1:0] srt_q;
    // Indexed [channel][0=A,1=B,2=C].
    logic [NUM_CH-1:0][2:0][CH_W-1:0]          abc_d;
    logic [NUM_CH-1:0][2:0][CH_W-1:0]          abc_q;
    logic [NUM_CH-1:0][CH_W-1:0]               med_c;

    assign en_c        = !vld3_q || axis_o.rdy;
    assign in_c        = axis_i.data;
    assign axis_i.rdy  = en_c;
    assign axis_o.vld  = vld3_q;
    assign axis_o.data = out_q;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic [CH_W-1:0] unused_a_lo;
        logic [CH_W-1:0] unused_a_md;
        logic [CH_W-1:0] unused_b_lo;
        logic [CH_W-1:0] unused_b_hi;
        logic [CH_W-1:0] unused_c_md;
        logic [CH_W-1:0] unused_c_hi;
        logic [CH_W-1:0] unused_m_lo;
        logic [CH_W-1:0] unused_m_hi;

        for (genvar row = 0; row < WIN; row++) begin : g_row
            median_filter_sort3 u_row (
                .a_i   (get_ch(in_c[row][0], ch)),
                .b_i   (get_ch(in_c[row][1], ch)),
                .c_i   (get_ch(in_c[row][2], ch)),
                .min_o (srt_d[ch][row][0]),
                .med_o (srt_d[ch][row][1]),
                .max_o (srt_d[ch][row][2])
            );
        end

        // A = largest row minimum, B = median of row medians, C = smallest row maximum.
        median_filter_sort3 u_a (
            .a_i   (srt_q[ch][0][0]),
            .b_i   (srt_q[ch][1][0]),
            .c_i   (srt_q[ch][2][0]),
            .min_o (unused_a_lo),
            .med_o (unused_a_md),
            .max_o (abc_d[ch][0])
        );

        median_filter_sort3 u_b (
            .a_i   (srt_q[ch][0][1]),
            .b_i   (srt_q[ch][1][1]),
            .c_i   (srt_q[ch][2][1]),
            .min_o (unused_b_lo),
            .med_o (abc_d[ch][1]),
            .max_o (unused_b_hi)
        );

        median_filter_sort3 u_c (
            .a_i   (srt_q[ch][0][2]),
            .b_i   (srt_q[ch][1][2]),
            .c_i   (srt_q[ch][2][2]),
            .min_o (abc_d[ch][2]),
            .med_o (unused_c_md),
            .max_o (unused_c_hi)
        );

        median_filter_sort3 u_m (
            .a_i   (abc_q[ch][0]),
            .b_i   (abc_q[ch][1]),
            .c_i   (abc_q[ch][2]),
            .min_o (unused_m_lo),
            .med_o (med_c[ch]),
            .max_o (unused_m_hi)
        );
    end

    // Centre pixel replaced by the median; the other eight ride along unchanged.
    always_comb begin
        out_d       = win2_q;
        out_d[1][1] = pixel_t'({med_c[0], med_c[1], med_c[2]});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld1_q <= 1'b0;
            vld2_q <= 1'b0;
            vld3_q <= 1'b0;
            win1_q <= '0;
            win2_q <= '0;
            out_q  <= '0;
            srt_q  <= '0;
            abc_q  <= '0;
        end else if (en_c) begin
            vld1_q <= axis_i.vld;
            win1_q <= in_c;
            srt_q  <= srt_d;
            vld2_q <= vld1_q;
            win2_q <= win1_q;
            abc_q  <= abc_d;
            vld3_q <= vld2_q;
            out_q  <= out_d;
        end
    end

endmodule

// File: tb/tb_median_filter.sv
// Directed and scoreboarded bench for the 3x3 median filter.
module tb_median_filter;
    import pixel_pkg::*;

    typedef struct {
        chunk_t d;
        int     cyc;
    } sb_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   cyc;
    bit   strict;
    sb_t  exp_q[$];

    axis_if #(.DATA_TYPE(chunk_t)) in_if ();
    axis_if #(.DATA_TYPE(chunk_t)) out_if ();

    median_filter dut (
        .clk    (clk),
        .rst    (rst),
        .axis_i (in_if),
        .axis_o (out_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic pixel_t px(int r, int g, int b);
        pixel_t p;
        p.red = 8'(r);
        p.grn = 8'(g);
        p.blu = 8'(b);
        return p;
    endfunction

    function automatic logic [7:0] chan(pixel_t p, int c);
        if (c == 0) return p.red;
        if (c == 1) return p.grn;
        return p.blu;
    endfunction

    // Reference: full sort of the nine samples per channel, take the fifth.
    function automatic chunk_t filt(chunk_t w);
        chunk_t     r;
        logic [7:0] v[9];
        logic [7:0] t;
        r = w;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 9; i++) v[i] = chan(w[i / 3][i % 3], c);
            for (int i = 1; i < 9; i++) begin
                for (int j = i; j > 0 && v[j - 1] > v[j]; j--) begin
                    t = v[j]; v[j] = v[j - 1]; v[j - 1] = t;
                end
            end
            if (c == 0) r[1][1].red = v[4];
            else if (c == 1) r[1][1].grn = v[4];
            else r[1][1].blu = v[4];
        end
        return r;
    endfunction

    function automatic chunk_t rand_win();
        chunk_t w;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[i][j] = pixel_t'(24'($urandom));
        return w;
    endfunction

    function automatic chunk_t flat_win(int v);
        chunk_t w;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[i][j] = px(v, v, v);
        return w;
    endfunction

    task automatic chk(string tag, logic [215:0] obs, logic [215:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: score the output handshake and record the input handshake, then advance.
    task automatic cycle();
        sb_t e;
        bit  acc_in;
        bit  acc_out;
        #1;
        acc_in  = in_if.vld && in_if.rdy && !rst;
        acc_out = out_if.vld && out_if.rdy;
        if (acc_out) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL spurious_out: observed %h expected no beat", out_if.data);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_data", 216'(out_if.data), 216'(e.d));
                if (strict) chk("latency", 216'(cyc - e.cyc), 216'(3));
            end
        end
        if (acc_in) begin
            e.d   = filt(in_if.data);
            e.cyc = cyc;
            exp_q.push_back(e);
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic send(chunk_t w);
        bit done;
        done       = 1'b0;
        in_if.vld  = 1'b1;
        in_if.data = w;
        for (int t = 0; t < 20 && !done; t++) begin
            #1;
            done = in_if.rdy;
            cycle();
        end
        checks++;
        assert (done) else begin
            errors++;
            $error("FAIL send_timeout: observed rdy %b expected 1", in_if.rdy);
        end
    endtask

    initial begin
        chunk_t w0;
        chunk_t d;
        errors     = 0;
        checks     = 0;
        cyc        = 0;
        strict     = 1'b0;
        rst        = 1'b1;
        w0         = rand_win();
        in_if.vld  = 1'b1;
        in_if.data = w0;
        out_if.rdy = 1'b1;
        #1;
        chk("rst_vld0", 216'(out_if.vld), 216'(1'b0));
        chk("rst_rdy0", 216'(in_if.rdy), 216'(1'b1));
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("rst_vld", 216'(out_if.vld), 216'(1'b0));
            chk("rst_rdy", 216'(in_if.rdy), 216'(1'b1));
        end

        // First beat after release: valid on the third edge, not before.
        rst    = 1'b0;
        strict = 1'b1;
        cycle();
        in_if.vld = 1'b0;
        chk("first_e1", 216'(out_if.vld), 216'(1'b0));
        cycle();
        chk("first_e2", 216'(out_if.vld), 216'(1'b0));
        cycle();
        chk("first_e3", 216'(out_if.vld), 216'(1'b1));
        chk("first_data", 216'(out_if.data), 216'(filt(w0)));
        cycle();

        // Hand-computed directed window.
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                d[i][j] = px(9 - (3 * i + j), 200, (3 * i + j) < 4 ? 0 : 255);
        send(d);
        in_if.vld = 1'b0;
        cycle();
        cycle();
        chk("dir_vld", 216'(out_if.vld), 216'(1'b1));
        chk("dir_centre", 216'(out_if.data[1][1]), 216'(px(5, 200, 255)));
        chk("dir_corner", 216'(out_if.data[0][0]), 216'(px(9, 200, 0)));
        chk("dir_edge", 216'(out_if.data[2][2]), 216'(px(1, 200, 255)));
        cycle();

        // Extremes back to back.
        send(flat_win(0));
        send(flat_win(255));
        in_if.vld = 1'b0;
        cycle();
        chk("zero_centre", 216'(out_if.data[1][1]), 216'(px(0, 0, 0)));
        cycle();
        chk("full_centre", 216'(out_if.data[1][1]), 216'(px(255, 255, 255)));
        cycle();

        // Random stream at full rate.
        for (int k = 0; k < 10; k++) send(rand_win());
        in_if.vld = 1'b0;
        for (int k = 0; k < 4; k++) cycle();
        chk("stream_drained", 216'(exp_q.size()), 216'(0));
        strict = 1'b0;

        // Backpressure with a full pipeline.
        for (int k = 0; k < 3; k++) send(rand_win());
        d          = rand_win();
        in_if.vld  = 1'b1;
        in_if.data = d;
        out_if.rdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("bp_in_rdy", 216'(in_if.rdy), 216'(1'b0));
            chk("bp_out_vld", 216'(out_if.vld), 216'(1'b1));
            if (exp_q.size() != 0) chk("bp_hold", 216'(out_if.data), 216'(exp_q[0].d));
            cycle();
        end
        out_if.rdy = 1'b1;
        send(d);
        send(rand_win());
        send(rand_win());
        in_if.vld = 1'b0;
        for (int k = 0; k < 6; k++) cycle();
        chk("bp_drained", 216'(exp_q.size()), 216'(0));

        // Reset with three beats in flight.
        for (int k = 0; k < 3; k++) send(rand_win());
        in_if.vld = 1'b0;
        chk("pre_rst_vld", 216'(out_if.vld), 216'(1'b1));
        #2 rst = 1'b1;
        #1;
        chk("async_rst_vld", 216'(out_if.vld), 216'(1'b0));
        exp_q.delete();
        cycle();
        cycle();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk("post_rst_vld", 216'(out_if.vld), 216'(1'b0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/median_filter.md
Name: median_filter

Overview:
- Streaming 3x3 median filter for the resistor-detector image pipeline.
- Each input beat is one 3x3 pixel window (pixel_pkg::chunk_t).
- For each beat, the block computes the per-channel median (red, grn, blu independently) of the 9 pixels and writes it into the centre of the output window.
- Sits between the window generator and colour classification, with AXI-Stream-style vld/rdy handshakes on both sides.

Parameters:
- None. Data types are fixed by pixel_pkg; pipeline latency is fixed at 3.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- axis_i  interface (axis_if, DATA_TYPE=pixel_pkg::chunk_t, sink side)  -  input window stream; vld/data in, rdy out.
- axis_o  interface (axis_if, DATA_TYPE=pixel_pkg::chunk_t, source side)  -  filtered window stream; vld/data out, rdy in.
- axis_if contents: vld (1), rdy (1), data (DATA_TYPE).
- chunk_t is pixel_t [3][3]; pixel_t = {red, grn, blu}, each 8-bit unsigned; 216 bits total.

Behaviour:
- One clock (clk); reset is asynchronous and active-high (rst).
- On rst: all stage valid flags = 0, so axis_o.vld = 0. Data registers reset to 0. axis_i.rdy follows the stall rule below, so it is 1 during and after reset.
- Pipeline has 3 register stages, each with a valid flag. Global enable en = !axis_o.vld || axis_o.rdy.
  - axis_i.rdy = en (combinational).
  - When en=1, every stage advances and stage-1 valid loads axis_i.vld.
  - When en=0, all stages hold, data and valid included.
- Latency: an input accepted at edge N appears on axis_o at edge N+3 when there is no backpressure. Throughput is 1 beat/cycle.
- Median algorithm, identical and independent for each channel c in {red, grn, blu}:
  - Stage 1: sort each row i (data[i][0..2]) ascending into min_i, med_i, max_i.
  - Stage 2: compute A = max(min_0, min_1, min_2), B = med(med_0, med_1, med_2), C = min(max_0, max_1, max_2).
  - Stage 3: median = med(A, B, C).
- Comparisons are unsigned 8-bit; ties resolve to either equal operand (value-identical).
- Output data:
  - data[1][1] = {median_red, median_grn, median_blu}.
  - The other 8 entries are the accepted input's entries, delayed 3 stages alongside.
- Invalid beats (vld=0) still flow through the registers; their data is don't-care. axis_o.vld marks valid beats only.
- Backpressure:
  - axis_o.rdy=0 while axis_o.vld=1 freezes the pipeline, and axis_o.data stays stable.
  - Bubbles (axis_o.vld=0) are always overwritten, even while rdy=0.
- rst asserted mid-stream: all in-flight beats are discarded immediately; no partial beat is emitted.

Decomposition:
- pixel_pkg holds: pixel_t struct {red, grn, blu : logic [7:0]}, chunk_t = pixel_t [3][3], and a CH_W=8 constant.
- axis_if is the shared interface with vld/rdy/data and modports.
- One sub-module is natural: sort3 (combinational; three 8-bit inputs -> min/med/max).
  - Instantiate 3 per channel in stage 1.
  - Stage 2 and stage 3 reuse it, taking the min/med/max outputs as needed.

Test Plan:
- Reset: hold rst=1 for 3 cycles with axis_i.vld=1 -> axis_o.vld=0 throughout; axis_i.rdy=1. First output appears 3 edges after rst is released.
- Random stream, vld=1 and rdy=1 constantly, 10 random windows with all channels in 0..255 -> each output centre equals a software per-channel median of its input, exactly 3 cycles later, with non-centre pixels passed through unchanged.
- Directed red values 9,8,7,6,5,4,3,2,1 (row-major) -> red median 5. Green all 200 -> 200. Blue {0,0,0,0,255,255,255,255,255} -> 255.
- Extremes: all channels 0 -> median 0; all channels 255 -> median 255; no wrap or sign issues.
- Backpressure: drop axis_o.rdy for 4 cycles while valid -> axis_o.data/vld are frozen, axis_i.rdy=0, and no beats are lost or duplicated after rdy returns.
- Mid-stream reset: assert rst with 3 beats in flight -> axis_o.vld drops asynchronously, and those beats never appear afterwards.
